// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter widths and the control-bit bundle
// carried through the sync delay line.
package vga_timing_pkg;

  // 640x480@60 Hz default raster parameters (pixel clocks / lines)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Coordinate widths seen by the pixel stage
  localparam int X_W = 10;
  localparam int Y_W = 9;

  // Counter widths: vcnt must reach 524, which does not fit in Y_W bits
  localparam int H_CNT_W = 10;
  localparam int V_CNT_W = 10;

  // Control bits that travel alongside the colour pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } ctrl_t;

  // Blanked, syncs deasserted (syncs are active-low)
  localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  // True when lo <= cnt < hi
  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Width x depth shift register with a per-bit reset value. Used to hold the
// raw sync/active bits back by the colour-stage latency.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // tap[0] is the input, tap[i+1] is the output of stage i
  logic [WIDTH-1:0] tap [DEPTH+1];

  assign tap[0] = din;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_reg;

      // One pipeline stage; reset loads the idle pattern so no stale
      // control bits survive a mid-frame reset
      always_ff @(posedge clk) begin
        if (reset) begin
          stage_reg <= RESET_VAL;
        end else begin
          stage_reg <= tap[gi];
        end
      end

      assign tap[gi+1] = stage_reg;
    end
  endgenerate

  assign dout = tap[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Presents coordinates to the pixel stage,
// delays sync/blank by the pixel-stage latency and registers colour so that
// sync, blank and RGB leave on the same clock edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  // Clocks from coordinate presentation to valid iR/iG/iB (1..8)
  parameter int PIPE_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     iR,
  input  logic [7:0]     iG,
  input  logic [7:0]     iB,
  output logic [X_W-1:0] oVGA_X,
  output logic [Y_W-1:0] oVGA_Y,
  output logic           oReq,
  output logic           oFrameStart,
  output logic           oVGA_HS,
  output logic           oVGA_VS,
  output logic           oVGA_BLANK_N,
  output logic           oVGA_SYNC_N,
  output logic [7:0]     oVGA_R,
  output logic [7:0]     oVGA_G,
  output logic [7:0]     oVGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode thresholds at counter width
  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START   = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END     = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_START   = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END     = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CNT_W-1:0] hcnt_reg;
  logic [V_CNT_W-1:0] vcnt_reg;

  logic  active;
  logic  hsync_raw;
  logic  vsync_raw;
  ctrl_t ctrl_raw;
  ctrl_t ctrl_dly;

  logic       hs_reg;
  logic       vs_reg;
  logic       blank_n_reg;
  logic [7:0] r_reg;
  logic [7:0] g_reg;
  logic [7:0] b_reg;

  // Raster counters: hcnt wraps every line, vcnt steps on each hcnt wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (hcnt_reg == H_LAST) begin
      hcnt_reg <= '0;
      vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + V_CNT_W'(1);
    end else begin
      hcnt_reg <= hcnt_reg + H_CNT_W'(1);
    end
  end

  // Window decode straight from the counter registers
  assign active    = (hcnt_reg < H_ACT_END) && (vcnt_reg < V_ACT_END);
  assign hsync_raw = ~in_window(hcnt_reg, HS_START, HS_END);
  assign vsync_raw = ~in_window(vcnt_reg, VS_START, VS_END);

  // Coordinates are parked at 0 outside the active region
  assign oVGA_X      = active ? hcnt_reg : '0;
  assign oVGA_Y      = active ? vcnt_reg[Y_W-1:0] : '0;
  assign oReq        = active;
  assign oFrameStart = (hcnt_reg == '0) && (vcnt_reg == '0);

  assign ctrl_raw.hs     = hsync_raw;
  assign ctrl_raw.vs     = vsync_raw;
  assign ctrl_raw.active = active;

  // Hold the control bits back until the matching colour arrives
  sync_delay_line #(
    .WIDTH    ($bits(ctrl_t)),
    .DEPTH    (PIPE_LAT),
    .RESET_VAL(CTRL_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .reset(reset),
    .din  (ctrl_raw),
    .dout (ctrl_dly)
  );

  // Pin register: syncs, blank and colour all update on the same edge;
  // colour is forced black whenever the aligned active bit is low
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_reg      <= 1'b1;
      vs_reg      <= 1'b1;
      blank_n_reg <= 1'b0;
      r_reg       <= '0;
      g_reg       <= '0;
      b_reg       <= '0;
    end else begin
      hs_reg      <= ctrl_dly.hs;
      vs_reg      <= ctrl_dly.vs;
      blank_n_reg <= ctrl_dly.active;
      r_reg       <= ctrl_dly.active ? iR : 8'h00;
      g_reg       <= ctrl_dly.active ? iG : 8'h00;
      b_reg       <= ctrl_dly.active ? iB : 8'h00;
    end
  end

  assign oVGA_HS      = hs_reg;
  assign oVGA_VS      = vs_reg;
  assign oVGA_BLANK_N = blank_n_reg;
  assign oVGA_R       = r_reg;
  assign oVGA_G       = g_reg;
  assign oVGA_B       = b_reg;
  assign oVGA_SYNC_N  = 1'b0;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing on the pixel clock and closes the loop with the pixel-colour stage. Drives pixel coordinates into `screenManager` (`iVGA_X`/`iVGA_Y`) and captures its registered RGB. Delays sync and blank by the colour pipeline latency so the DAC-facing outputs (sync, blank, colour) leave the block aligned on the same clock edge. Sits directly downstream of `screenManager` and directly upstream of the board VGA DAC pins.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `PIPE_LAT`, 1, clocks from coordinate presentation to valid `iR/iG/iB`; legal range 1..8

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in 1 pixel clock
- `reset` in 1 synchronous, active-high
- `iR`, `iG`, `iB` in 8 each: colour from the pixel stage
- `oVGA_X` out 10: current column
- `oVGA_Y` out 9: current row
- `oReq` out 1: coordinates are in the active region
- `oFrameStart` out 1: one-cycle pulse at pixel (0,0), coordinate-aligned
- `oVGA_HS`, `oVGA_VS` out 1: active-low syncs, pin-aligned
- `oVGA_BLANK_N` out 1: high during active video, pin-aligned
- `oVGA_SYNC_N` out 1: constant 0
- `oVGA_R`, `oVGA_G`, `oVGA_B` out 8 each: pin colour

## Operation
- **Counters.** `hcnt` runs 0..H_TOTAL-1, where H_TOTAL = 800 by default. `vcnt` runs 0..V_TOTAL-1, where V_TOTAL = 525 by default.
- **Wrap.** `vcnt` increments when `hcnt` wraps; both wrap together at the frame end.
- **Active region.** Active when `hcnt` < H_ACTIVE and `vcnt` < V_ACTIVE.
- **Coordinates.**
  - `oVGA_X` = `hcnt` and `oVGA_Y` = `vcnt` while active; both are 0 otherwise.
  - `oReq` = active.
  - All three are combinational from the counter registers only.
- **Sync windows.**
  - hsync_raw is low for H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync_raw is low for whole lines V_ACTIVE+V_FP ≤ `vcnt` < V_ACTIVE+V_FP+V_SYNC (490..491).
- **Sync delay.** {hsync_raw, vsync_raw, active} pass through a PIPE_LAT-stage shift register, then one output register. Total delay is PIPE_LAT+1.
- **Colour capture.**
  - The output register loads `iR/iG/iB` when the delayed active bit is 1.
  - It loads 0 when the delayed active bit is 0, so blanking is black regardless of input.
- **Frame start.** `oFrameStart` = (`hcnt`==0 && `vcnt`==0), undelayed. Downstream animation state uses it as the frame tick.
- **Constant output.** `oVGA_SYNC_N` is tied to 0.

## Timing
- **Reset values.**
  - `hcnt` = `vcnt` = 0.
  - All shift-register stages hold inactive values: HS=1, VS=1, active=0.
  - `oVGA_HS` = `oVGA_VS` = 1; `oVGA_BLANK_N` = 0; `oVGA_R/G/B` = 0.
  - Combinational outputs therefore show `oVGA_X` = `oVGA_Y` = 0, `oReq` = 1 and `oFrameStart` = 1 while reset is held.
- **First cycle after reset deasserts.** The counters are at (0,0) and advance to (1,0) on the next edge. Reset mid-frame takes effect on the next edge and needs no flush; the delay line is re-initialised.
- **Latency.** Coordinates presented at cycle t produce pin colour, HS, VS and BLANK_N at cycle t+PIPE_LAT+1.
- **Frame length.** Exactly H_TOTAL×V_TOTAL = 420000 clocks; HS period 800 clocks.
- **Simultaneous wrap.** At `hcnt`=799, `vcnt`=524 both counters return to 0 on the same edge and `oFrameStart` asserts in the following cycle.
- **Input sampling.** Inputs are sampled only on the edge where the delayed active bit is 1. No handshake; the pixel stage must meet PIPE_LAT exactly.

## Structure
- **Shared package `vga_timing_pkg`:**
  - default porch/sync/active constants;
  - derived H_TOTAL and V_TOTAL;
  - coordinate widths (10/9).
- **Sub-module `sync_delay_line`:** a parameterised width×depth shift register with per-bit reset value. It carries the 3 control bits.
- **Top level:** the counters, window decode and colour output register stay in the top module.

## Test plan
1. **Reset values.** Hold reset 5 cycles → `oVGA_HS`=1, `oVGA_VS`=1, `oVGA_BLANK_N`=0, RGB=0, `oVGA_X`=0, `oVGA_Y`=0. After release, `oVGA_X` reads 1 on the second cycle.
2. **Horizontal timing (PIPE_LAT=1).**
   - Pin `oVGA_HS` falls at cycle 658 after release (656+2) and rises at cycle 754.
   - `oVGA_BLANK_N` is high for cycles 2..641.
   - Successive HS falling edges are 800 apart.
3. **Vertical timing.**
   - `oVGA_VS` is low for exactly 1600 clocks starting at clock 490×800+2.
   - `oFrameStart` pulses every 420000 clocks.
4. **Alignment.**
   - Stimulus: drive `iR` = X[7:0] delayed by PIPE_LAT, `iG` = Y[7:0].
   - At the pin, the `oVGA_R` sequence is 0,1,2,…; `oVGA_R` = `oVGA_G` = 0 whenever `oVGA_BLANK_N`=0.
   - Run with PIPE_LAT=1 and again with PIPE_LAT=3.
5. **Reset mid-frame.** Assert reset at `vcnt`=200, `hcnt`=300 for 1 cycle → counters return to (0,0), and the delay line drives 1+PIPE_LAT inactive cycles before active video resumes.
6. **Blank forcing.** Hold `iR/iG/iB` = 8'hFF constant → pin colour is 0 throughout both porches and both sync intervals.
